// File: rtl/enemy_spawner.sv
// enemy_spawner
//   Paces enemy spawns in waves. Each wave waits COOLDOWN game ticks between
//   spawns, grants the lowest-index idle slot, waits for the field to clear,
//   pauses BREAK_TICKS game ticks and starts the next, larger wave.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high
//   gameTick   : one-clk pulse per game step
//   enable     : 1 = run, 0 = freeze (lockouts still count down)
//   dead       : per-slot idle flag from each Enemy
//   canSpawn   : one-hot spawn grant, one-clk pulse
//   spawnType  : type of the granted enemy (1..3), 0 when no grant
//   waveNum    : current wave index, saturating at 15
//   waveActive : 1 while in COOLDOWN, SPAWN or CLEAR
module enemy_spawner #(
    parameter int NUM_SLOTS   = 4,
    parameter int COOLDOWN    = 8,
    parameter int WAVE_BASE   = 4,
    parameter int BREAK_TICKS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 gameTick,
    input  logic                 enable,
    input  logic [NUM_SLOTS-1:0] dead,
    output logic [NUM_SLOTS-1:0] canSpawn,
    output logic [1:0]           spawnType,
    output logic [3:0]           waveNum,
    output logic                 waveActive
);

    localparam int CW = $clog2(COOLDOWN + 2);
    localparam int SW = $clog2(WAVE_BASE + 17);
    localparam int BW = $clog2(BREAK_TICKS + 2);

    typedef enum logic [4:0] {
        S_IDLE     = 5'b00001,
        S_COOLDOWN = 5'b00010,
        S_SPAWN    = 5'b00100,
        S_CLEAR    = 5'b01000,
        S_BREAK    = 5'b10000
    } state_t;

    state_t                      r_state, w_state_nxt;
    logic [CW-1:0]               r_cool, w_cool_nxt;
    logic [SW-1:0]               r_spawn_cnt, w_spawn_nxt;
    logic [BW-1:0]               r_break, w_break_nxt;
    logic [3:0]                  r_wave, w_wave_nxt, w_wave_inc;
    logic [7:0]                  r_lfsr, w_lfsr_nxt;
    logic [NUM_SLOTS-1:0][1:0]   r_lock, w_lock_nxt;
    logic [NUM_SLOTS-1:0]        w_lock_clr, w_elig, w_grant;
    logic [NUM_SLOTS-1:0]        r_can_spawn;
    logic [1:0]                  r_spawn_type, w_type;
    logic                        r_wave_active;
    logic                        w_fire;

    // Eligible = idle and out of lockout; x & -x isolates the lowest set bit.
    assign w_elig     = dead & w_lock_clr;
    assign w_grant    = w_elig & (-w_elig);
    assign w_wave_inc = (r_wave == 4'd15) ? 4'd15 : r_wave + 4'd1;
    assign w_type     = (r_wave == 4'd0 || r_lfsr[1:0] == 2'd0) ? 2'd1 : r_lfsr[1:0];

    // Lockouts run regardless of enable so an Enemy's slow dead-deassert
    // cannot cause a double grant after a freeze.
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_lock
        assign w_lock_clr[g] = (r_lock[g] == 2'd0);
        assign w_lock_nxt[g] = (w_fire && w_grant[g]) ? 2'd3 :
                               (w_lock_clr[g] ? 2'd0 : r_lock[g] - 2'd1);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cool_nxt  = r_cool;
        w_spawn_nxt = r_spawn_cnt;
        w_break_nxt = r_break;
        w_wave_nxt  = r_wave;
        w_lfsr_nxt  = r_lfsr;
        w_fire      = 1'b0;
        if (enable) begin
            if (gameTick) begin
                w_lfsr_nxt = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
            end
            unique case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_COOLDOWN;
                    w_cool_nxt  = CW'(COOLDOWN);
                    w_spawn_nxt = SW'(WAVE_BASE) + SW'(r_wave);
                end
                S_COOLDOWN: begin
                    if (r_cool == '0) begin
                        w_state_nxt = S_SPAWN;
                    end else if (gameTick) begin
                        w_cool_nxt = r_cool - CW'(1);
                    end
                end
                S_SPAWN: begin
                    // Cooldown reload here wins over any coincident gameTick,
                    // since decrementing only happens in COOLDOWN.
                    if (w_elig != '0) begin
                        w_fire      = 1'b1;
                        w_spawn_nxt = r_spawn_cnt - SW'(1);
                        w_cool_nxt  = CW'(COOLDOWN);
                        w_state_nxt = (r_spawn_cnt <= SW'(1)) ? S_CLEAR : S_COOLDOWN;
                    end
                end
                S_CLEAR: begin
                    if ((&dead) && (&w_lock_clr)) begin
                        w_state_nxt = S_BREAK;
                        w_break_nxt = BW'(BREAK_TICKS);
                    end
                end
                S_BREAK: begin
                    if (r_break == '0) begin
                        w_wave_nxt  = w_wave_inc;
                        w_cool_nxt  = CW'(COOLDOWN);
                        w_spawn_nxt = SW'(WAVE_BASE) + SW'(w_wave_inc);
                        w_state_nxt = S_COOLDOWN;
                    end else if (gameTick) begin
                        w_break_nxt = r_break - BW'(1);
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cool        <= '0;
            r_spawn_cnt   <= '0;
            r_break       <= '0;
            r_wave        <= '0;
            r_lfsr        <= 8'hA5;
            r_lock        <= '0;
            r_can_spawn   <= '0;
            r_spawn_type  <= '0;
            r_wave_active <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cool        <= w_cool_nxt;
            r_spawn_cnt   <= w_spawn_nxt;
            r_break       <= w_break_nxt;
            r_wave        <= w_wave_nxt;
            r_lfsr        <= w_lfsr_nxt;
            r_lock        <= w_lock_nxt;
            r_can_spawn   <= w_fire ? w_grant : '0;
            r_spawn_type  <= w_fire ? w_type : 2'd0;
            r_wave_active <= (w_state_nxt == S_COOLDOWN) || (w_state_nxt == S_SPAWN) ||
                             (w_state_nxt == S_CLEAR);
        end
    end

    assign canSpawn   = r_can_spawn;
    assign spawnType  = r_spawn_type;
    assign waveNum    = r_wave;
    assign waveActive = r_wave_active;

endmodule
